// File: rtl/eth_tx_frame_ctrl.sv
// Ethernet MAC transmit frame sequencer.
// Starts the preamble/SFD generator, streams AXI-Stream payload into the CRC
// engine and onto a registered GMII byte interface, appends the FCS and
// enforces the inter-frame gap. Payload underflow aborts the frame with
// tx_er and drains the rest of the packet.
// Optional build macro ETH_TX_PAD_EN: when defined, frames shorter than
// MIN_PAYLOAD are zero-padded (PAD state); otherwise they go out unpadded.
module eth_tx_frame_ctrl #(
`ifdef ETH_TX_PAD_EN
    parameter int MIN_PAYLOAD = 60,
`endif
    parameter int IFG_BYTES = 12
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic        pre_start,
    input  logic        pre_done,
    input  logic [7:0]  pre_data,
    output logic        crc_clear,
    output logic        crc_en,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_value,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic        frame_done,
    output logic        underflow
);

    localparam int IFG_W = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_BYTES - 1);
`ifdef ETH_TX_PAD_EN
    localparam logic [11:0] MIN_LEN = 12'(MIN_PAYLOAD);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_PAYLOAD, S_PAD, S_FCS, S_IFG, S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [10:0]      byte_cnt_q, byte_cnt_d;
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
    logic [1:0]       fcs_cnt_q, fcs_cnt_d;
    // Upper three FCS bytes; the low byte goes straight to GMII when latched.
    logic [23:0]      crc_q, crc_d;
    logic [7:0]       txd_q, txd_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_er_q, tx_er_d;
    logic             frame_done_q, frame_done_d;
    logic             underflow_q, underflow_d;

    // Frame length counter saturates instead of wrapping on jumbo frames.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    assign busy       = (state_q != S_IDLE);
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;

    // State, counters and the registered GMII/status outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            ifg_cnt_q    <= '0;
            fcs_cnt_q    <= '0;
            crc_q        <= '0;
            txd_q        <= '0;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            ifg_cnt_q    <= ifg_cnt_d;
            fcs_cnt_q    <= fcs_cnt_d;
            crc_q        <= crc_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
        end
    end

    // Next-state logic, GMII byte mux and the combinational strobes.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        ifg_cnt_d     = ifg_cnt_q;
        fcs_cnt_d     = fcs_cnt_q;
        crc_d         = crc_q;
        txd_d         = 8'h00;
        tx_en_d       = 1'b0;
        tx_er_d       = 1'b0;
        frame_done_d  = 1'b0;
        underflow_d   = 1'b0;
        s_axis_tready = 1'b0;
        pre_start     = 1'b0;
        crc_clear     = 1'b0;
        crc_en        = 1'b0;
        crc_data      = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                byte_cnt_d = '0;
                ifg_cnt_d  = '0;
                fcs_cnt_d  = '0;
                if (s_axis_tvalid) begin
                    pre_start = 1'b1;
                    crc_clear = 1'b1;
                    state_d   = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                txd_d   = pre_data;
                tx_en_d = 1'b1;
                if (pre_done) state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                s_axis_tready = 1'b1;
                tx_en_d       = 1'b1;
                if (s_axis_tvalid) begin
                    txd_d      = s_axis_tdata;
                    crc_en     = 1'b1;
                    crc_data   = s_axis_tdata;
                    byte_cnt_d = sat_inc(byte_cnt_q);
                    if (s_axis_tlast) begin
`ifdef ETH_TX_PAD_EN
                        if (({1'b0, byte_cnt_q} + 12'd1) < MIN_LEN) state_d = S_PAD;
                        else state_d = S_FCS;
`else
                        state_d = S_FCS;
`endif
                    end
                end else begin
                    // Source starved mid-frame: poison the frame and drop the rest.
                    tx_er_d     = 1'b1;
                    underflow_d = 1'b1;
                    state_d     = S_DRAIN;
                end
            end
`ifdef ETH_TX_PAD_EN
            S_PAD: begin
                tx_en_d    = 1'b1;
                crc_en     = 1'b1;
                byte_cnt_d = sat_inc(byte_cnt_q);
                // Leave on the last pad byte so FCS follows without a gap.
                if (({1'b0, byte_cnt_q} + 12'd1) >= MIN_LEN) state_d = S_FCS;
            end
`endif
            S_FCS: begin
                tx_en_d   = 1'b1;
                fcs_cnt_d = fcs_cnt_q + 2'd1;
                unique case (fcs_cnt_q)
                    2'd0: begin
                        txd_d = crc_value[7:0];
                        crc_d = crc_value[31:8];
                    end
                    2'd1: txd_d = crc_q[7:0];
                    2'd2: txd_d = crc_q[15:8];
                    default: begin
                        txd_d        = crc_q[23:16];
                        frame_done_d = 1'b1;
                        state_d      = S_IFG;
                    end
                endcase
            end
            S_IFG: begin
                ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
                if (ifg_cnt_q == IFG_LAST) begin
                    ifg_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            S_DRAIN: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = S_IFG;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_tx_frame_ctrl.sv
// Self-checking bench for eth_tx_frame_ctrl. Models the preamble generator
// and an external CRC engine, captures every GMII byte sent with tx_en or
// tx_er, and compares against an expected byte queue built from the stimulus.
module tb_eth_tx_frame_ctrl;

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif
    localparam int MIN_PAY = 60;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        pre_start;
    logic        pre_done;
    logic [7:0]  pre_data;
    logic        crc_clear;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc_value;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        frame_done;
    logic        underflow;

    always #5 aclk = ~aclk;

    eth_tx_frame_ctrl dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .pre_start(pre_start), .pre_done(pre_done), .pre_data(pre_data),
        .crc_clear(crc_clear), .crc_en(crc_en), .crc_data(crc_data),
        .crc_value(crc_value),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .busy(busy), .frame_done(frame_done), .underflow(underflow)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // Simple mixing function standing in for CRC-32 on both sides.
    function automatic logic [31:0] crc_step(input logic [31:0] acc, input logic [7:0] b);
        return {acc[30:0], acc[31]} ^ {b, b ^ 8'h5A, 8'h00, b} ^ 32'h04C1_1DB7;
    endfunction

    // Preamble generator: 7 x 0x55 then SFD with pre_done.
    int   pre_cnt;
    logic pre_done_x;
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (areset) pre_cnt <= 0;
        else if (pre_start) pre_cnt <= 1;
        else if (pre_cnt == 8) pre_cnt <= 0;
        else if (pre_cnt != 0) pre_cnt <= pre_cnt + 1;
    end
    assign pre_done = (pre_cnt == 8) || pre_done_x;
    assign pre_data = (pre_cnt == 8) ? 8'hD5 : ((pre_cnt != 0) ? 8'h55 : 8'h00);

    // CRC engine: value only valid the cycle after the last crc_en.
    logic [31:0] crc_acc;
    logic        crc_vld;
    always @(posedge aclk) begin
        crc_vld <= crc_en;
        if (crc_clear) crc_acc <= 32'hFFFF_FFFF;
        else if (crc_en) crc_acc <= crc_step(crc_acc, crc_data);
    end
    assign crc_value = crc_vld ? ~crc_acc : 32'hA5A5_0F0F;

    // Output monitor.
    logic [8:0] cap_q[$];
    int gap_q[$];
    int fd_cnt = 0, uf_cnt = 0, crc_cnt = 0, er_cnt = 0, last_txen_cyc = 0;
    always @(negedge aclk) begin
        if (gmii_tx_en || gmii_tx_er) cap_q.push_back({gmii_tx_er, gmii_txd});
        if (gmii_tx_en) last_txen_cyc <= cyc;
        if (pre_start) gap_q.push_back(cyc - last_txen_cyc);
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (underflow) uf_cnt <= uf_cnt + 1;
        if (crc_en) crc_cnt <= crc_cnt + 1;
        if (gmii_tx_er && gmii_tx_en && underflow) er_cnt <= er_cnt + 1;
    end

    logic [8:0] exp_q[$];
    int rd_idx = 0;

    // Drives one AXI packet; pushes expected GMII bytes as stimulus is accepted.
    task automatic axi_send(input int len, input logic [7:0] base, input int drop_at);
        int i = 0;
        int guard = 0;
        int npad;
        bit dropped = 1'b0;
        bit hs;
        logic [31:0] acc = 32'hFFFF_FFFF;
        for (int k = 0; k < 7; k++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        while (i < len && guard < 4000) begin
            if (i == drop_at && !dropped) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                dropped = 1'b1;
                exp_q.push_back({1'b1, 8'h00});
                repeat (3) @(posedge aclk);
                #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 8'(i);
            s_axis_tlast  = (i == len - 1);
            @(negedge aclk);
            hs = s_axis_tready;
            @(posedge aclk);
            #1;
            guard++;
            if (hs) begin
                if (!dropped) begin
                    exp_q.push_back({1'b0, s_axis_tdata});
                    acc = crc_step(acc, s_axis_tdata);
                end
                i++;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checks++;
        if (guard >= 4000) $display("FAIL axi_send_timeout: accepted %0d bytes, required %0d", i, len);
        else passes++;
        if (!dropped) begin
            npad = (PAD_ON && len < MIN_PAY) ? MIN_PAY - len : 0;
            for (int k = 0; k < npad; k++) begin
                exp_q.push_back(9'h000);
                acc = crc_step(acc, 8'h00);
            end
            acc = ~acc;
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, acc[8*k +: 8]});
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            @(posedge aclk);
            #1;
            n++;
        end
    endtask

    // Pops the expected queue against newly captured bytes; returns mismatch count.
    function automatic int stream_diff(output int first_idx, output logic [8:0] got,
                                       output logic [8:0] want);
        int bad = 0;
        int n_cap = cap_q.size() - rd_idx;
        logic [8:0] g;
        first_idx = -1;
        got = '0;
        want = '0;
        for (int k = 0; k < exp_q.size(); k++) begin
            g = (k < n_cap) ? cap_q[rd_idx + k] : 9'h1FF;
            if (g !== exp_q[k]) begin
                if (bad == 0) begin
                    first_idx = k;
                    got = g;
                    want = exp_q[k];
                end
                bad++;
            end
        end
        rd_idx = cap_q.size();
        exp_q.delete();
        return bad;
    endfunction

    task automatic test_reset();
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tdata = 8'h00;
        pre_done_x = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({gmii_tx_en, gmii_tx_er, gmii_txd} !== 10'h0)
            $display("FAIL reset_gmii: got %h, required 000", {gmii_tx_en, gmii_tx_er, gmii_txd});
        else passes++;
        checks++;
        if ({busy, s_axis_tready, pre_start, crc_clear, crc_en, crc_data, frame_done, underflow} !== 15'h0)
            $display("FAIL reset_ctrl: got %h, required 0000",
                     {busy, s_axis_tready, pre_start, crc_clear, crc_en, crc_data, frame_done, underflow});
        else passes++;
        @(posedge aclk);
        #1 areset = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({busy, gmii_tx_en} !== 2'b00) $display("FAIL idle_hold: got %b, required 00", {busy, gmii_tx_en});
        else passes++;
        rd_idx = cap_q.size();
    endtask

    task automatic test_long_frame();
        int n, ne, nc, bad, fi;
        int f0 = fd_cnt, c0 = crc_cnt, u0 = uf_cnt;
        logic [8:0] g, w;
        axi_send(64, 8'h00, -1);
        wait_idle(n);
        checks++;
        if (n !== 16) $display("FAIL long_busy_tail: got %0d cycles, required 16", n);
        else passes++;
        ne = exp_q.size();
        nc = cap_q.size() - rd_idx;
        checks++;
        if (nc !== ne) $display("FAIL long_len: got %0d bytes, required %0d", nc, ne);
        else passes++;
        bad = stream_diff(fi, g, w);
        checks++;
        if (bad !== 0) $display("FAIL long_stream: byte %0d got %h, required %h", fi, g, w);
        else passes++;
        checks++;
        if (fd_cnt - f0 !== 1) $display("FAIL long_frame_done: got %0d, required 1", fd_cnt - f0);
        else passes++;
        checks++;
        if (crc_cnt - c0 !== 64) $display("FAIL long_crc_en: got %0d, required 64", crc_cnt - c0);
        else passes++;
        checks++;
        if (uf_cnt - u0 !== 0) $display("FAIL long_underflow: got %0d, required 0", uf_cnt - u0);
        else passes++;
    endtask

    task automatic test_short_frame();
        int n, ne, nc, bad, fi;
        int c0 = crc_cnt, f0 = fd_cnt;
        logic [8:0] g, w;
        axi_send(10, 8'hA0, -1);
        wait_idle(n);
        checks++;
        if (n !== (PAD_ON ? 66 : 16)) $display("FAIL short_busy_tail: got %0d, required %0d", n, PAD_ON ? 66 : 16);
        else passes++;
        ne = exp_q.size();
        nc = cap_q.size() - rd_idx;
        checks++;
        if (nc !== ne) $display("FAIL short_len: got %0d bytes, required %0d", nc, ne);
        else passes++;
        bad = stream_diff(fi, g, w);
        checks++;
        if (bad !== 0) $display("FAIL short_stream: byte %0d got %h, required %h", fi, g, w);
        else passes++;
        checks++;
        if (crc_cnt - c0 !== (PAD_ON ? 60 : 10))
            $display("FAIL short_crc_en: got %0d, required %0d", crc_cnt - c0, PAD_ON ? 60 : 10);
        else passes++;
        checks++;
        if (fd_cnt - f0 !== 1) $display("FAIL short_frame_done: got %0d, required 1", fd_cnt - f0);
        else passes++;
    endtask

    task automatic test_underflow();
        int n, ne, nc, bad, fi;
        int f0 = fd_cnt, u0 = uf_cnt, c0 = crc_cnt, e0 = er_cnt;
        logic [8:0] g, w;
        axi_send(100, 8'h10, 20);
        wait_idle(n);
        checks++;
        if (n !== 12) $display("FAIL uf_ifg: got %0d cycles, required 12", n);
        else passes++;
        ne = exp_q.size();
        nc = cap_q.size() - rd_idx;
        checks++;
        if (nc !== ne) $display("FAIL uf_len: got %0d bytes, required %0d", nc, ne);
        else passes++;
        bad = stream_diff(fi, g, w);
        checks++;
        if (bad !== 0) $display("FAIL uf_stream: byte %0d got %h, required %h", fi, g, w);
        else passes++;
        checks++;
        if (uf_cnt - u0 !== 1) $display("FAIL uf_pulse: got %0d, required 1", uf_cnt - u0);
        else passes++;
        checks++;
        if (er_cnt - e0 !== 1) $display("FAIL uf_er_with_en: got %0d, required 1", er_cnt - e0);
        else passes++;
        checks++;
        if (fd_cnt - f0 !== 0) $display("FAIL uf_frame_done: got %0d, required 0", fd_cnt - f0);
        else passes++;
        checks++;
        if (crc_cnt - c0 !== 20) $display("FAIL uf_crc_en: got %0d, required 20", crc_cnt - c0);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n, ne, nc, bad, fi, gap;
        int f0 = fd_cnt;
        logic [8:0] g, w;
        axi_send(60, 8'h40, -1);
        fork
            axi_send(60, 8'h80, -1);
            begin
                repeat (6) @(posedge aclk);
                #1 pre_done_x = 1'b1;
                @(posedge aclk);
                #1 pre_done_x = 1'b0;
            end
        join
        wait_idle(n);
        gap = (gap_q.size() > 0) ? gap_q[$] : -1;
        checks++;
        if (gap !== 12) $display("FAIL b2b_gap: got %0d cycles, required 12", gap);
        else passes++;
        ne = exp_q.size();
        nc = cap_q.size() - rd_idx;
        checks++;
        if (nc !== ne) $display("FAIL b2b_len: got %0d bytes, required %0d", nc, ne);
        else passes++;
        bad = stream_diff(fi, g, w);
        checks++;
        if (bad !== 0) $display("FAIL b2b_stream: byte %0d got %h, required %h", fi, g, w);
        else passes++;
        checks++;
        if (fd_cnt - f0 !== 2) $display("FAIL b2b_frame_done: got %0d, required 2", fd_cnt - f0);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int i = 0, guard = 0, n, ne, nc, bad, fi, u0;
        bit hs;
        logic [8:0] g, w;
        u0 = uf_cnt;
        while (i < 30 && guard < 500) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 8'(i);
            s_axis_tlast = 1'b0;
            @(negedge aclk);
            hs = s_axis_tready;
            @(posedge aclk);
            #1;
            guard++;
            if (hs) i++;
        end
        s_axis_tdata = 8'd30;
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({gmii_tx_en, busy, s_axis_tready, gmii_tx_er} !== 4'b0000)
            $display("FAIL rst_mid: got %b, required 0000", {gmii_tx_en, busy, s_axis_tready, gmii_tx_er});
        else passes++;
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (uf_cnt - u0 !== 0) $display("FAIL rst_mid_no_error: got %0d underflows, required 0", uf_cnt - u0);
        else passes++;
        rd_idx = cap_q.size();
        exp_q.delete();
        @(posedge aclk);
        #1;
        axi_send(20, 8'hC0, -1);
        wait_idle(n);
        ne = exp_q.size();
        nc = cap_q.size() - rd_idx;
        checks++;
        if (nc !== ne) $display("FAIL rst_new_len: got %0d bytes, required %0d", nc, ne);
        else passes++;
        bad = stream_diff(fi, g, w);
        checks++;
        if (bad !== 0) $display("FAIL rst_new_stream: byte %0d got %h, required %h", fi, g, w);
        else passes++;
    endtask

    task automatic test_one_byte();
        int n, ne, nc, bad, fi, c0;
        logic [8:0] g, w;
        c0 = crc_cnt;
        axi_send(1, 8'h5C, -1);
        wait_idle(n);
        checks++;
        if (n !== (PAD_ON ? 75 : 16)) $display("FAIL one_busy_tail: got %0d, required %0d", n, PAD_ON ? 75 : 16);
        else passes++;
        checks++;
        if (crc_cnt - c0 !== (PAD_ON ? 60 : 1))
            $display("FAIL one_crc_en: got %0d, required %0d", crc_cnt - c0, PAD_ON ? 60 : 1);
        else passes++;
        ne = exp_q.size();
        nc = cap_q.size() - rd_idx;
        checks++;
        if (nc !== ne) $display("FAIL one_len: got %0d bytes, required %0d", nc, ne);
        else passes++;
        bad = stream_diff(fi, g, w);
        checks++;
        if (bad !== 0) $display("FAIL one_stream: byte %0d got %h, required %h", fi, g, w);
        else passes++;
        c0 = crc_cnt;
        axi_send(10, 8'h21, -1);
        wait_idle(n);
        checks++;
        if (crc_cnt - c0 !== (PAD_ON ? 60 : 10))
            $display("FAIL next_crc_en: got %0d, required %0d", crc_cnt - c0, PAD_ON ? 60 : 10);
        else passes++;
        bad = stream_diff(fi, g, w);
        checks++;
        if (bad !== 0) $display("FAIL next_stream: byte %0d got %h, required %h", fi, g, w);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_long_frame();
        test_short_frame();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        test_one_byte();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
